absdiff_unit: RTL and testbench

Iterative 4-bit absolute-difference unit with latency-insensitive val/rdy streams on input and output. An FSM control unit sequences a small datapath of 4-bit 2:1 muxes, operand registers, a less-than comparator and a subtractor. It consumes an operand pair {a, b} from upstream and produces |a − b| downstream. It is the control-plus-datapath stage that drives the select lines of the team's 4-bit 2:1 mux components.

---
 rtl/absdiff_pkg.sv | 26 ++
 rtl/absdiff_dpath.sv | 85 ++++++++
 rtl/absdiff_unit.sv | 93 +++++++++
 tb/tb_absdiff_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/absdiff_pkg.sv
// ============================================================================
// Module      : absdiff_pkg
// Description : Shared types and constants for the absolute-difference unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package absdiff_pkg;

    localparam int ABSDIFF_NBITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A-register input select; bit 1 picks the difference, bit 0 picks B over the operand
    localparam logic [1:0] ASEL_LOAD = 2'd0;
    localparam logic [1:0] ASEL_SWAP = 2'd1;
    localparam logic [1:0] ASEL_SUB  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/absdiff_dpath.sv
// ============================================================================
// Module      : absdiff_dpath
// Description : Operand registers, 2:1 mux trees, comparator and subtractor.
//               ABSDIFF_SIGNED_EN selects a signed comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module absdiff_mux2
    import absdiff_pkg::*;
(
    input  logic                     i_sel,
    input  logic [ABSDIFF_NBITS-1:0] i_in0,
    input  logic [ABSDIFF_NBITS-1:0] i_in1,
    output logic [ABSDIFF_NBITS-1:0] o_out
);
    assign o_out = i_sel ? i_in1 : i_in0;
endmodule

module absdiff_dpath
    import absdiff_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ABSDIFF_NBITS-1:0] i_in_a,
    input  logic [ABSDIFF_NBITS-1:0] i_in_b,
    input  logic [1:0]               a_sel,
    input  logic                     a_en,
    input  logic                     b_sel,
    input  logic                     b_en,
    output logic                     a_lt_b,
    output logic [ABSDIFF_NBITS-1:0] result
);

    logic [ABSDIFF_NBITS-1:0] r_a;
    logic [ABSDIFF_NBITS-1:0] r_b;
    logic [ABSDIFF_NBITS-1:0] w_diff;
    logic [ABSDIFF_NBITS-1:0] w_a_lvl0;
    logic [ABSDIFF_NBITS-1:0] w_a_next;
    logic [ABSDIFF_NBITS-1:0] w_b_next;

    // Three A sources folded into two 2:1 stages: operand/B, then that/difference
    absdiff_mux2 u_a_mux0 (
        .i_sel (a_sel[0]),
        .i_in0 (i_in_a),
        .i_in1 (r_b),
        .o_out (w_a_lvl0)
    );

    absdiff_mux2 u_a_mux1 (
        .i_sel (a_sel[1]),
        .i_in0 (w_a_lvl0),
        .i_in1 (w_diff),
        .o_out (w_a_next)
    );

    absdiff_mux2 u_b_mux (
        .i_sel (b_sel),
        .i_in0 (i_in_b),
        .i_in1 (r_a),
        .o_out (w_b_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (a_en) r_a <= w_a_next;
            if (b_en) r_b <= w_b_next;
        end
    end

`ifdef ABSDIFF_SIGNED_EN
    assign a_lt_b = $signed(r_a) < $signed(r_b);
`else
    assign a_lt_b = r_a < r_b;
`endif

    assign w_diff = r_a - r_b;
    assign result = r_a;

endmodule

`default_nettype wire

// File: rtl/absdiff_unit.sv
// ============================================================================
// Module      : absdiff_unit
// Description : Iterative 4-bit |a - b| with val/rdy streams (FSM + handshake).
//               ABSDIFF_SIGNED_EN treats operands as two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module absdiff_unit
    import absdiff_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     istream_val,
    output logic                     istream_rdy,
    input  logic [ABSDIFF_NBITS-1:0] istream_msg_a,
    input  logic [ABSDIFF_NBITS-1:0] istream_msg_b,
    output logic                     ostream_val,
    input  logic                     ostream_rdy,
    output logic [ABSDIFF_NBITS-1:0] ostream_msg
);

    state_e                   r_state;
    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic [1:0]               w_a_sel;
    logic                     w_a_en;
    logic                     w_b_sel;
    logic                     w_b_en;
    logic                     w_a_lt_b;
    logic [ABSDIFF_NBITS-1:0] w_result;

    // rst gating keeps rdy low while reset is held even though state is already IDLE
    assign istream_rdy = (r_state == IDLE) && rst;
    assign ostream_val = (r_state == DONE);
    assign ostream_msg = ostream_val ? w_result : '0;
    assign w_in_xfer   = istream_val && istream_rdy;
    assign w_out_xfer  = ostream_val && ostream_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_in_xfer) r_state <= SWAP;
                SWAP:    r_state <= SUB;
                SUB:     r_state <= DONE;
                DONE:    if (w_out_xfer) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_a_sel = ASEL_LOAD;
        w_a_en  = 1'b0;
        w_b_sel = 1'b0;
        w_b_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_a_en = w_in_xfer;
                w_b_en = w_in_xfer;
            end
            SWAP: begin
                w_a_sel = ASEL_SWAP;
                w_b_sel = 1'b1;
                w_a_en  = w_a_lt_b;
                w_b_en  = w_a_lt_b;
            end
            SUB: begin
                w_a_sel = ASEL_SUB;
                w_a_en  = 1'b1;
            end
            default: ;
        endcase
    end

    absdiff_dpath u_dpath (
        .clk    (clk),
        .rst    (rst),
        .i_in_a (istream_msg_a),
        .i_in_b (istream_msg_b),
        .a_sel  (w_a_sel),
        .a_en   (w_a_en),
        .b_sel  (w_b_sel),
        .b_en   (w_b_en),
        .a_lt_b (w_a_lt_b),
        .result (w_result)
    );

endmodule

`default_nettype wire

// File: tb/tb_absdiff_unit.sv
// ============================================================================
// Module      : tb_absdiff_unit
// Description : Directed self-checking bench for absdiff_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_absdiff_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       istream_val;
    logic       istream_rdy;
    logic [3:0] istream_msg_a;
    logic [3:0] istream_msg_b;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [3:0] ostream_msg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    absdiff_unit dut (
        .clk           (clk),
        .rst           (rst),
        .istream_val   (istream_val),
        .istream_rdy   (istream_rdy),
        .istream_msg_a (istream_msg_a),
        .istream_msg_b (istream_msg_b),
        .ostream_val   (ostream_val),
        .ostream_rdy   (ostream_rdy),
        .ostream_msg   (ostream_msg)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full transaction with ostream_rdy high; starts and ends at a falling edge in IDLE
    task automatic run_txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] exp);
        chk({tag, "_rdy_idle"}, 4'(istream_rdy), 4'd1);
        istream_val   = 1'b1;
        istream_msg_a = a;
        istream_msg_b = b;
        @(negedge clk);
        istream_val = 1'b0;
        chk({tag, "_rdy_swap"}, 4'(istream_rdy), 4'd0);
        chk({tag, "_val_swap"}, 4'(ostream_val), 4'd0);
        @(negedge clk);
        chk({tag, "_val_sub"}, 4'(ostream_val), 4'd0);
        chk({tag, "_msg_sub"}, ostream_msg, 4'd0);
        @(negedge clk);
        chk({tag, "_val_done"}, 4'(ostream_val), 4'd1);
        chk({tag, "_msg"}, ostream_msg, exp);
        @(negedge clk);
        chk({tag, "_rdy_after"}, 4'(istream_rdy), 4'd1);
        chk({tag, "_val_after"}, 4'(ostream_val), 4'd0);
    endtask

    initial begin
        rst           = 1'b0;
        istream_val   = 1'b0;
        istream_msg_a = '0;
        istream_msg_b = '0;
        ostream_rdy   = 1'b1;

        @(negedge clk);
        chk("rst_rdy", 4'(istream_rdy), 4'd0);
        chk("rst_val", 4'(ostream_val), 4'd0);
        chk("rst_msg", ostream_msg, 4'd0);
        rst = 1'b1;
        #1;
        chk("rel_rdy", 4'(istream_rdy), 4'd1);
        @(negedge clk);

        run_txn("basic", 4'd9, 4'd3, 4'd6);
        run_txn("swap", 4'd3, 4'd9, 4'd6);
        run_txn("equal", 4'd7, 4'd7, 4'd0);
`ifdef ABSDIFF_SIGNED_EN
        run_txn("ext_hi_lo", 4'd15, 4'd0, 4'd1);
        run_txn("ext_lo_hi", 4'd0, 4'd15, 4'd1);
        run_txn("cfg", 4'b1000, 4'b0111, 4'd15);
`else
        run_txn("ext_hi_lo", 4'd15, 4'd0, 4'd15);
        run_txn("ext_lo_hi", 4'd0, 4'd15, 4'd15);
        run_txn("cfg", 4'b1000, 4'b0111, 4'd1);
`endif

        // Back-pressure: result must hold for five stalled cycles
        ostream_rdy   = 1'b0;
        istream_val   = 1'b1;
        istream_msg_a = 4'd12;
        istream_msg_b = 4'd5;
        @(negedge clk);
        istream_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_val", 4'(ostream_val), 4'd1);
            chk("bp_msg", ostream_msg, 4'd7);
            chk("bp_rdy", 4'(istream_rdy), 4'd0);
            @(negedge clk);
        end
        chk("bp_val_end", 4'(ostream_val), 4'd1);
        ostream_rdy = 1'b1;
        @(negedge clk);
        chk("bp_val_xfer", 4'(ostream_val), 4'd0);
        chk("bp_rdy_xfer", 4'(istream_rdy), 4'd1);
        @(negedge clk);
        chk("bp_single", 4'(ostream_val), 4'd0);

        // New pair presented during SWAP/SUB/DONE is only taken once back in IDLE
        istream_val   = 1'b1;
        istream_msg_a = 4'd2;
        istream_msg_b = 4'd10;
        @(negedge clk);
        istream_msg_a = 4'd13;
        istream_msg_b = 4'd1;
        chk("ign_rdy_swap", 4'(istream_rdy), 4'd0);
        @(negedge clk);
        chk("ign_val_sub", 4'(ostream_val), 4'd0);
        @(negedge clk);
        chk("ign_val1", 4'(ostream_val), 4'd1);
        chk("ign_msg1", ostream_msg, 4'd8);
        @(negedge clk);
        chk("ign_rdy_idle", 4'(istream_rdy), 4'd1);
        chk("ign_val_idle", 4'(ostream_val), 4'd0);
        @(negedge clk);
        istream_val = 1'b0;
        chk("b2b_rdy_swap", 4'(istream_rdy), 4'd0);
        @(negedge clk);
        chk("b2b_val_sub", 4'(ostream_val), 4'd0);
        @(negedge clk);
        chk("b2b_val2", 4'(ostream_val), 4'd1);
`ifdef ABSDIFF_SIGNED_EN
        chk("b2b_msg2", ostream_msg, 4'd4);
`else
        chk("b2b_msg2", ostream_msg, 4'd12);
`endif
        @(negedge clk);
        chk("b2b_rdy_end", 4'(istream_rdy), 4'd1);

        // Reset asserted during SUB aborts the transaction
        istream_val   = 1'b1;
        istream_msg_a = 4'd9;
        istream_msg_b = 4'd3;
        @(negedge clk);
        istream_val = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_val", 4'(ostream_val), 4'd0);
        chk("mrst_msg", ostream_msg, 4'd0);
        chk("mrst_rdy", 4'(istream_rdy), 4'd0);
        @(negedge clk);
        chk("mrst_val2", 4'(ostream_val), 4'd0);
        chk("mrst_msg2", ostream_msg, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_rel_rdy", 4'(istream_rdy), 4'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst_no_stale", 4'(ostream_val), 4'd0);
        end

        run_txn("post_rst", 4'd4, 4'd11, 4'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
